// File: rtl/uart_pkg.sv
// Shared UART definitions: configuration encodings, receiver states and
// the baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        ODD   = 2'b01,
        EVEN  = 2'b10,
        NONE2 = 2'b11
    } parity_t;

    typedef enum logic [1:0] {
        B2400  = 2'b00,
        B4800  = 2'b01,
        B9600  = 2'b10,
        B19200 = 2'b11
    } baud_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5,
        WAIT_HIGH = 3'd6
    } rx_state_t;

    localparam int DIV_W = 16;

    // Rounded clocks per oversample tick for a given baud code.
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                  input int unsigned oversample,
                                                  input baud_t       code);
        int unsigned baud;
        int unsigned denom;
        int unsigned div;
        case (code)
            B2400:   baud = 2400;
            B4800:   baud = 4800;
            B9600:   baud = 9600;
            default: baud = 19200;
        endcase
        denom = baud * oversample;
        div   = (clk_freq + denom / 2) / denom;
        return div[DIV_W-1:0];
    endfunction

    function automatic logic parity_enabled(input parity_t p);
        return (p == ODD) || (p == EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every baud_div() clocks,
// restartable so the tick phase can be aligned to a start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear_i,
    input  baud_t baud_i,
    output logic  tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_last;
    logic             wrap;

    assign div_last = baud_div(CLK_FREQ, OVERSAMPLE, baud_i) - {{(DIV_W-1){1'b0}}, 1'b1};

    always_comb begin
        wrap  = (cnt_q >= div_last);
        cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        if (clear_i || wrap) begin
            cnt_d = '0;
        end
    end

    // A clear suppresses the tick so the first tick lands one full period later.
    assign tick_o = wrap && !clear_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, 8 data bits LSB first,
// optional parity, one stop bit; reports byte with parity/framing status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       active_flag,
    output logic       done_flag,
    output logic       parity_error,
    output logic       stop_error
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    rx_state_t     state_q,    state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic          par_err_q,  par_err_d;
    baud_t         baud_q,     baud_d;
    parity_t       parity_q,   parity_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          perr_q,     perr_d;
    logic          serr_q,     serr_d;
    logic          active_q,   active_d;
    logic          done_q,     done_d;

    logic tick;
    logic tick_clear;
    logic frame_xor;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tick_clear),
        .baud_i  (baud_q),
        .tick_o  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= data_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign frame_xor = ^{shift_q, rx_s_q};

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        baud_d     = baud_q;
        parity_d   = parity_q;
        data_out_d = data_out_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        active_d   = active_q;
        done_d     = 1'b0;
        tick_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = START;
                    active_d   = 1'b1;
                    tick_clear = 1'b1;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    par_err_d  = 1'b0;
                    baud_d     = baud_t'(baud_rate);
                    parity_d   = parity_t'(parity_type);
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            state_d  = IDLE;
                            active_d = 1'b0;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = parity_enabled(parity_q) ? PARITY : STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
            end

            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // Odd expects an odd total of ones over data+parity, even an even total.
                        par_err_d  = (parity_q == ODD) ? ~frame_xor : frame_xor;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = DONE;
                        data_out_d = shift_q;
                        perr_d     = par_err_q;
                        serr_d     = ~rx_s_q;
                        done_d     = 1'b1;
                        active_d   = 1'b0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
            end

            DONE: begin
                state_d = rx_s_q ? IDLE : WAIT_HIGH;
            end

            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            baud_q     <= B2400;
            parity_q   <= NONE;
            data_out_q <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            baud_q     <= baud_d;
            parity_q   <= parity_d;
            data_out_q <= data_out_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    // Results are registered on the stop sample so they coincide with the DONE cycle.
    assign data_out     = data_out_q;
    assign parity_error = perr_q;
    assign stop_error   = serr_q;
    assign active_flag  = active_q;
    assign done_flag    = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frames are serialised from a bit-level
// description, expected results queued, and a monitor checks every done pulse.
module tb_uart_rx;

    localparam int unsigned F_CLK = 800_000;

    logic       clk;
    logic       rst_n;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_out;
    logic       active_flag;
    logic       done_flag;
    logic       parity_error;
    logic       stop_error;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    int   exp_dones = 0;

    uart_rx #(
        .CLK_FREQ   (F_CLK),
        .OVERSAMPLE (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_rx      (data_rx),
        .parity_type  (parity_type),
        .baud_rate    (baud_rate),
        .data_out     (data_out),
        .active_flag  (active_flag),
        .done_flag    (done_flag),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clocks per oversample tick: nearest integer to f/(16*baud).
    function automatic int tick_div(input logic [1:0] code);
        real baud;
        baud = 2400.0 * (2.0 ** code);
        return $rtoi(real'(F_CLK) / (16.0 * baud) + 0.5);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] par, input logic [1:0] br,
                              input bit bad_par, input bit stop_val, input bit hold_low,
                              input int abort_bit);
        int   bc;
        bit   pen;
        bit   pbit;
        int   ones;
        exp_t e;
        bc   = 16 * tick_div(br);
        pen  = (par == 2'b01) || (par == 2'b10);
        ones = $countones(d);
        if (par == 2'b01) pbit = ((ones % 2) == 0);
        else              pbit = ((ones % 2) == 1);
        pbit = pbit ^ bad_par;
        if (abort_bit < 0) begin
            e.d  = d;
            e.pe = pen && bad_par;
            e.se = !stop_val;
            q.push_back(e);
            exp_dones++;
        end
        parity_type = par;
        baud_rate   = br;
        data_rx     = 1'b0;
        wait_clks(bc / 2);
        parity_type = 2'($urandom);
        baud_rate   = 2'($urandom);
        wait_clks(bc - bc / 2);
        for (int i = 0; i < 8; i++) begin
            data_rx = d[i];
            if (abort_bit == i) begin
                wait_clks(bc / 2);
                rst_n = 1'b0;
                wait_clks(2);
                chk("abort_data_out", data_out, 0);
                chk("abort_active", active_flag, 0);
                chk("abort_stop_err", stop_error, 0);
                chk("abort_par_err", parity_error, 0);
                data_rx = 1'b1;
                wait_clks(2);
                rst_n = 1'b1;
                wait_clks(bc);
                return;
            end
            wait_clks(bc);
        end
        if (pen) begin
            data_rx = pbit;
            wait_clks(bc);
        end
        data_rx = stop_val;
        wait_clks(bc);
        if (!hold_low) data_rx = 1'b1;
    endtask

    initial begin
        bit prev_done;
        int bc9600;
        rst_n       = 1'b0;
        data_rx     = 1'b1;
        parity_type = 2'b00;
        baud_rate   = 2'b10;
        bc9600      = 16 * tick_div(2'b10);

        fork
            begin
                exp_t e;
                prev_done = 1'b0;
                forever begin
                    @(negedge clk);
                    if (prev_done) chk("done_pulse_width", done_flag, 0);
                    if (done_flag) begin
                        done_cnt++;
                        $display("RX byte=%02h parity_error=%0b stop_error=%0b t=%0t",
                                 data_out, parity_error, stop_error, $time);
                        chk("done_expected", (q.size() > 0), 1);
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            chk("data_out", data_out, e.d);
                            chk("parity_error", parity_error, e.pe);
                            chk("stop_error", stop_error, e.se);
                        end
                    end
                    prev_done = done_flag;
                end
            end
        join_none

        wait_clks(10);
        chk("rst_data_out", data_out, 0);
        chk("rst_active", active_flag, 0);
        chk("rst_done", done_flag, 0);
        chk("rst_par_err", parity_error, 0);
        chk("rst_stop_err", stop_error, 0);
        rst_n = 1'b1;
        wait_clks(20);

        send_frame(8'h4A, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hAA, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, -1);
        send_frame(8'hCC, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, -1);
        wait_clks(2 * bc9600);
        send_frame(8'h81, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, -1);

        // Break condition: the line stays low past the bad stop bit.
        send_frame(8'hCC, 2'b11, 2'b10, 1'b0, 1'b0, 1'b1, -1);
        wait_clks(3 * bc9600);
        chk("break_active", active_flag, 0);
        chk("break_done_count", done_cnt, exp_dones);
        data_rx = 1'b1;
        wait_clks(bc9600);
        chk("break_exit_done_count", done_cnt, exp_dones);

        send_frame(8'hA5, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 4);
        send_frame(8'h3C, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, -1);
        wait_clks(bc9600);

        // Low glitch of about 0.38 bit is rejected at the start-bit mid-sample.
        baud_rate   = 2'b10;
        parity_type = 2'b01;
        data_rx     = 1'b0;
        wait_clks(4 * tick_div(2'b10));
        chk("glitch_active_high", active_flag, 1);
        wait_clks(2 * tick_div(2'b10));
        data_rx = 1'b1;
        wait_clks(bc9600);
        chk("glitch_active_low", active_flag, 0);
        chk("glitch_done_count", done_cnt, exp_dones);

        for (int b = 0; b < 4; b++) begin
            send_frame(8'h00, 2'b01, 2'(b), 1'b0, 1'b1, 1'b0, -1);
            send_frame(8'hFF, 2'b01, 2'(b), 1'b0, 1'b1, 1'b0, -1);
            send_frame(8'h55, 2'b01, 2'(b), 1'b0, 1'b1, 1'b0, -1);
            wait_clks(20);
        end

        for (int n = 0; n < 14; n++) begin
            send_frame(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)),
                       ($urandom_range(0, 3) == 0), 1'b1, 1'b0, -1);
            wait_clks($urandom_range(0, 20));
        end

        for (int t = 0; t < 1000 && q.size() > 0; t++) wait_clks(1);
        chk("queue_drained", q.size(), 0);
        chk("total_done_count", done_cnt, exp_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
